// File: rtl/odometer_beat_counter_stacked_pkg.sv
// Shared types and constants for the stacked odometer beat counter.
// Defaults match the production beat-counter and deadzone widths.
package odometer_pkg;

  localparam int CNT_W_DEF       = 12;
  localparam int DZ_W_DEF        = 14;
  localparam int BLANK_DEF       = 8;
  localparam int SYNC_STAGES_DEF = 2;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARM     = 3'd1,
    ST_COUNT   = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  function automatic logic [31:0] sat_max(input int w);
    sat_max = (32'd1 << w) - 32'd1;
  endfunction

  localparam logic [31:0] CNT_MAX = sat_max(CNT_W_DEF);

endpackage

// File: rtl/odometer_beat_counter_stacked_if.sv
// Control/result bundle between the beat counter and its driver.
// The slave modport is the counter side.
interface odometer_beat_counter_stacked_if
  import odometer_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
);

  logic             ENABLE;
  logic             PD_IN;
  logic [CNT_W-1:0] BF_COUNTER;
  logic             DETECT;
  logic             DEADZONE_COUNTER_MSB;
  logic             MEAS_DONE;

  modport master (
    output ENABLE,
    output PD_IN,
    input  BF_COUNTER,
    input  DETECT,
    input  DEADZONE_COUNTER_MSB,
    input  MEAS_DONE
  );

  modport slave (
    input  ENABLE,
    input  PD_IN,
    output BF_COUNTER,
    output DETECT,
    output DEADZONE_COUNTER_MSB,
    output MEAS_DONE
  );

endinterface

// File: rtl/odometer_beat_counter_stacked_pd_sync_edge.sv
// Synchronizes the asynchronous phase-detector output and emits a registered
// one-cycle pulse on each falling edge of the synchronized level.
module pd_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic pd_in,
  output logic beat_event
);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   prev_r;
  logic                   event_r;

  // Sync chain resets low so the first high sample cannot look like a falling edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_r  <= '0;
      prev_r  <= 1'b0;
      event_r <= 1'b0;
    end else begin
      sync_r[0] <= pd_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_r[i] <= sync_r[i-1];
      end
      prev_r  <= sync_r[SYNC_STAGES-1];
      event_r <= prev_r & ~sync_r[SYNC_STAGES-1];
    end
  end

  assign beat_event = event_r;

endmodule

// File: rtl/odometer_beat_counter_stacked.sv
// Single-shot beat-period measurement: counts CLK cycles between two accepted
// phase-detector falling edges, with blanking and a deadzone timeout.
module odometer_beat_counter_stacked
  import odometer_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int DZ_W        = DZ_W_DEF,
  parameter int BLANK       = BLANK_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input logic                        CLK,
  input logic                        RESET,
  odometer_beat_counter_stacked_if.slave bus
);

  localparam logic [CNT_W-1:0] SAT_VAL   = CNT_W'((CNT_W == CNT_W_DEF) ? CNT_MAX : sat_max(CNT_W));
  localparam logic [CNT_W-1:0] BLANK_CNT = CNT_W'(BLANK);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [DZ_W-1:0]  DZ_ONE    = DZ_W'(1);

  state_t           state_r;
  logic [CNT_W-1:0] bf_r;
  logic [DZ_W-1:0]  dz_r;
  logic             detect_r;
  logic             meas_done_r;

  logic             beat_event_s;
  logic [DZ_W-1:0]  dz_inc_s;
  logic [CNT_W-1:0] bf_inc_s;
  logic             timeout_s;
  logic             accept_s;

  pd_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_pd_sync_edge (
    .clk        (CLK),
    .rst        (RESET),
    .pd_in      (bus.PD_IN),
    .beat_event (beat_event_s)
  );

  // Next deadzone/beat values; bf_r starts at 1 in COUNT so it equals the
  // elapsed cycle distance from the first event, which doubles as the blank timer.
  always_comb begin
    dz_inc_s  = dz_r + DZ_ONE;
    timeout_s = dz_inc_s[DZ_W-1];
    if (bf_r == SAT_VAL) begin
      bf_inc_s = bf_r;
    end else begin
      bf_inc_s = bf_r + CNT_ONE;
    end
    accept_s = beat_event_s && (bf_r > BLANK_CNT);
  end

  // Measurement FSM with registered outputs; timeout takes priority over events.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_r     <= ST_IDLE;
      bf_r        <= '0;
      dz_r        <= '0;
      detect_r    <= 1'b0;
      meas_done_r <= 1'b0;
    end else begin
      meas_done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (bus.ENABLE) begin
            bf_r    <= '0;
            dz_r    <= '0;
            state_r <= ST_ARM;
          end
        end
        ST_ARM: begin
          if (timeout_s) begin
            dz_r        <= dz_inc_s;
            detect_r    <= 1'b0;
            meas_done_r <= 1'b1;
            state_r     <= ST_DONE;
          end else if (beat_event_s) begin
            dz_r     <= '0;
            bf_r     <= CNT_ONE;
            detect_r <= 1'b1;
            state_r  <= ST_COUNT;
          end else begin
            dz_r <= dz_inc_s;
          end
        end
        ST_COUNT: begin
          if (timeout_s) begin
            dz_r        <= dz_inc_s;
            detect_r    <= 1'b0;
            meas_done_r <= 1'b1;
            state_r     <= ST_DONE;
          end else if (accept_s) begin
            state_r <= ST_CAPTURE;
          end else begin
            bf_r <= bf_inc_s;
            dz_r <= dz_inc_s;
          end
        end
        ST_CAPTURE: begin
          detect_r    <= 1'b0;
          meas_done_r <= 1'b1;
          state_r     <= ST_DONE;
        end
        ST_DONE: begin
          if (!bus.ENABLE) begin
            dz_r    <= '0;
            state_r <= ST_IDLE;
          end
        end
        default: begin
          detect_r <= 1'b0;
          state_r  <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.BF_COUNTER           = bf_r;
  assign bus.DETECT               = detect_r;
  assign bus.DEADZONE_COUNTER_MSB = dz_r[DZ_W-1];
  assign bus.MEAS_DONE            = meas_done_r;

endmodule

// File: tb/tb_odometer_beat_counter_stacked.sv
// Self-checking bench for odometer_beat_counter_stacked: directed scenarios plus
// randomized periods compared against a cycle-distance reference model.
module tb_odometer_beat_counter_stacked;

  localparam int BLANK = 8;
  localparam int TMO   = 8192;
  localparam int SAT   = 4095;

  logic CLK   = 1'b0;
  logic RESET = 1'b1;

  int tests_run    = 0;
  int tests_failed = 0;

  odometer_beat_counter_stacked_if #(.CNT_W(12)) bus ();

  odometer_beat_counter_stacked #(
    .CNT_W       (12),
    .DZ_W        (14),
    .BLANK       (8),
    .SYNC_STAGES (2)
  ) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  // Reference: first edge starts, first edge more than BLANK later stops,
  // distance >= TMO (or no stop) is a timeout.
  function automatic void model_meas(input int o[3], input int n,
                                     output int bf, output bit to, output int hi);
    bit decided;
    int d;
    bf = 0; to = 1'b1; hi = 0; decided = 1'b0;
    if (n > 0) begin
      bf = SAT; hi = TMO;
      for (int i = 1; i < n; i++) begin
        d = o[i] - o[0];
        if (!decided && d > BLANK) begin
          decided = 1'b1;
          if (d < TMO) begin
            to = 1'b0;
            bf = (d > SAT) ? SAT : d;
            hi = d + 1;
          end
        end
      end
    end
  endfunction

  task automatic test_reset();
    bit hit;
    int md, dt;
    bus.ENABLE = 1'b0;
    bus.PD_IN  = 1'b1;
    RESET      = 1'b1;
    repeat (3) @(negedge CLK);
    tests_run++;
    if (bus.BF_COUNTER !== 12'd0 || bus.DETECT !== 1'b0 ||
        bus.DEADZONE_COUNTER_MSB !== 1'b0 || bus.MEAS_DONE !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_init: got bf=%0d det=%b dz=%b md=%b, need all 0",
               bus.BF_COUNTER, bus.DETECT, bus.DEADZONE_COUNTER_MSB, bus.MEAS_DONE);
    end
    RESET = 1'b0;
    @(negedge CLK);
    hit = 1'b0;
    bus.ENABLE = 1'b1;
    for (int c = 0; c < 2000 && !hit; c++) begin
      @(negedge CLK);
      if (bus.BF_COUNTER === 12'd50 && bus.DETECT === 1'b1) hit = 1'b1;
      else bus.PD_IN = (c >= 10 && c < 12) ? 1'b0 : 1'b1;
    end
    tests_run++;
    if (!hit) begin
      tests_failed++;
      $display("FAIL reset_reach50: got bf=%0d, need 50 within budget", bus.BF_COUNTER);
    end
    #2 RESET = 1'b1;
    #1;
    tests_run++;
    if (bus.BF_COUNTER !== 12'd0 || bus.DETECT !== 1'b0 ||
        bus.DEADZONE_COUNTER_MSB !== 1'b0 || bus.MEAS_DONE !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_async: got bf=%0d det=%b dz=%b md=%b, need all 0",
               bus.BF_COUNTER, bus.DETECT, bus.DEADZONE_COUNTER_MSB, bus.MEAS_DONE);
    end
    @(negedge CLK);
    RESET = 1'b0;
    bus.ENABLE = 1'b0;
    md = 0; dt = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge CLK);
      if (bus.MEAS_DONE === 1'b1) md++;
      if (bus.DETECT === 1'b1) dt++;
    end
    tests_run++;
    if (md != 0 || dt != 0 || bus.BF_COUNTER !== 12'd0) begin
      tests_failed++;
      $display("FAIL reset_idle: got md=%0d det=%0d bf=%0d, need 0 0 0", md, dt, bus.BF_COUNTER);
    end
  endtask

  task automatic run_meas(input string name, input int o0, input int o1, input int o2,
                          input int n, input int drop_at);
    int o[3];
    int exp_bf, exp_hi;
    bit exp_to;
    int hi_cnt, md_cnt, md_c, fall_c, bf_last_hi;
    bit seen_hi, done, flag_done;
    logic pd;
    o[0] = o0; o[1] = o1; o[2] = o2;
    model_meas(o, n, exp_bf, exp_to, exp_hi);
    hi_cnt = 0; md_cnt = 0; md_c = -1; fall_c = -1; bf_last_hi = -1;
    seen_hi = 1'b0; done = 1'b0; flag_done = 1'b0;
    for (int c = 0; c < 12000 && !done; c++) begin
      @(negedge CLK);
      if (bus.DETECT === 1'b1) begin
        hi_cnt++;
        seen_hi    = 1'b1;
        bf_last_hi = int'(bus.BF_COUNTER);
      end else if (seen_hi && fall_c < 0) begin
        fall_c = c;
      end
      if (bus.MEAS_DONE === 1'b1) begin
        md_cnt++;
        if (md_c < 0) begin
          md_c      = c;
          flag_done = bus.DEADZONE_COUNTER_MSB;
        end
      end
      if (md_c >= 0 && c >= md_c + 3) done = 1'b1;
      bus.ENABLE = (drop_at >= 0 && c >= drop_at) ? 1'b0 : 1'b1;
      pd = 1'b1;
      for (int i = 0; i < n; i++) begin
        if (c >= o[i] && c < o[i] + 2) pd = 1'b0;
      end
      bus.PD_IN = pd;
    end
    tests_run++;
    if (!done) begin
      tests_failed++;
      $display("FAIL %s_budget: got no MEAS_DONE, need one within 12000 cycles", name);
    end
    tests_run++;
    if (bus.BF_COUNTER !== 12'(exp_bf)) begin
      tests_failed++;
      $display("FAIL %s_bf: got %0d, need %0d", name, bus.BF_COUNTER, exp_bf);
    end
    tests_run++;
    if (flag_done !== exp_to) begin
      tests_failed++;
      $display("FAIL %s_dzflag: got %b, need %b", name, flag_done, exp_to);
    end
    tests_run++;
    if (hi_cnt != exp_hi) begin
      tests_failed++;
      $display("FAIL %s_detect_len: got %0d cycles high, need %0d", name, hi_cnt, exp_hi);
    end
    tests_run++;
    if (md_cnt != 1) begin
      tests_failed++;
      $display("FAIL %s_meas_done_cnt: got %0d pulses, need 1", name, md_cnt);
    end
    if (n > 0) begin
      tests_run++;
      if (md_c != fall_c || bf_last_hi != exp_bf) begin
        tests_failed++;
        $display("FAIL %s_fall_align: got md@%0d fall@%0d bf_at_fall=%0d, need md@fall bf=%0d",
                 name, md_c, fall_c, bf_last_hi, exp_bf);
      end
    end
    bus.ENABLE = 1'b0;
    bus.PD_IN  = 1'b1;
    repeat (3) @(negedge CLK);
    tests_run++;
    if (bus.DEADZONE_COUNTER_MSB !== 1'b0 || bus.BF_COUNTER !== 12'(exp_bf) ||
        bus.DETECT !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s_after_disable: got dz=%b bf=%0d det=%b, need 0 %0d 0",
               name, bus.DEADZONE_COUNTER_MSB, bus.BF_COUNTER, bus.DETECT, exp_bf);
    end
  endtask

  task automatic test_nominal();
    run_meas("nominal", 10, 110, 0, 2, -1);
  endtask

  task automatic test_blanking();
    run_meas("blanking", 10, 14, 310, 3, -1);
    run_meas("blank_edge8", 10, 18, 22, 3, -1);
    run_meas("blank_edge9", 10, 19, 0, 2, -1);
  endtask

  task automatic test_saturation();
    run_meas("saturation", 10, 5010, 0, 2, -1);
  endtask

  task automatic test_timeout();
    run_meas("timeout_count", 10, 0, 0, 1, -1);
    run_meas("timeout_arm", 0, 0, 0, 0, -1);
  endtask

  task automatic test_control();
    run_meas("enable_drop", 10, 210, 0, 2, 50);
    run_meas("coincident", 10, 10 + TMO, 0, 2, -1);
  endtask

  task automatic test_random();
    int s, p, g;
    for (int k = 0; k < 4; k++) begin
      s = int'($urandom_range(20, 5));
      p = int'($urandom_range(3000, 9));
      g = int'($urandom_range(8, 4));
      if (p >= g + 4 && $urandom_range(1, 0) == 1) run_meas("rand_glitch", s, s + g, s + p, 3, -1);
      else run_meas("rand", s, s + p, 0, 2, -1);
    end
  endtask

  initial begin
    bus.ENABLE = 1'b0;
    bus.PD_IN  = 1'b1;
    test_reset();
    test_nominal();
    test_blanking();
    test_saturation();
    test_timeout();
    test_control();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
